mem_arbiter: RTL

Arbitrates one shared single-port memory between the fetch (instruction) requester and the mem-stage (data) requester.
- Sits between the fetch/mem stages and the unified memory bus.
- Routes each response to its owner.
- Discards wrong-path instruction responses when the controller asserts its one-cycle soft reset.
- Gives data requests priority, with a starvation guard for fetch.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_picker.sv | 41 ++++
 rtl/mem_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM states and bus-owner encoding.
package mem_arb_pkg;

  localparam int ADDR_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ_I,
    ST_REQ_D,
    ST_WAIT_I,
    ST_WAIT_D
  } mem_arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } mem_arb_owner_e;

endpackage

// File: rtl/mem_arb_picker.sv
// Winner selection for the arbiter: data has priority unless fetch has lost
// STARVE_LIMIT consecutive grants while it was requesting.
module mem_arb_picker
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  input  logic           i_req,
  input  logic           d_req,
  input  logic           i_gnt,
  input  logic           d_gnt,
  output mem_arb_owner_e winner
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      starve_q <= '0;
    end else if (i_gnt) begin
      starve_q <= '0;
    end else if (d_gnt && i_req && (starve_q != LIMIT)) begin
      starve_q <= starve_q + CNT_W'(1);
    end
  end

  always_comb begin
    winner = OWN_NONE;
    if (i_req && (!d_req || (starve_q == LIMIT))) begin
      winner = OWN_I;
    end else if (d_req) begin
      winner = OWN_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-outstanding memory port between fetch and data requesters,
// routes responses back to their owner and drops wrong-path fetch responses on flush.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = mem_arb_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    softresetn_i,
  input  logic                    i_req_i,
  input  logic [ADDR_WIDTH-1:0]   i_addr_i,
  output logic                    i_gnt_o,
  output logic                    i_rvalid_o,
  output logic [DATA_WIDTH-1:0]   i_rdata_o,
  input  logic                    d_req_i,
  input  logic                    d_we_i,
  input  logic [DATA_WIDTH/8-1:0] d_be_i,
  input  logic [ADDR_WIDTH-1:0]   d_addr_i,
  input  logic [DATA_WIDTH-1:0]   d_wdata_i,
  output logic                    d_gnt_o,
  output logic                    d_rvalid_o,
  output logic [DATA_WIDTH-1:0]   d_rdata_o,
  output logic                    m_req_o,
  output logic                    m_we_o,
  output logic [DATA_WIDTH/8-1:0] m_be_o,
  output logic [ADDR_WIDTH-1:0]   m_addr_o,
  output logic [DATA_WIDTH-1:0]   m_wdata_o,
  input  logic                    m_gnt_i,
  input  logic                    m_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   m_rdata_i
);

  mem_arb_state_e state_q, state_d;
  mem_arb_owner_e owner, winner;
  logic           drop_q;

  mem_arb_picker #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_picker (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .i_req  (i_req_i),
    .d_req  (d_req_i),
    .i_gnt  (i_gnt_o),
    .d_gnt  (d_gnt_o),
    .winner (winner)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A flush marks an issued fetch as wrong-path; the flag lives until its response is consumed.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      drop_q <= 1'b0;
    end else if ((state_q == ST_WAIT_I) && m_rvalid_i) begin
      drop_q <= 1'b0;
    end else if (!softresetn_i && ((state_q == ST_WAIT_I) || i_gnt_o)) begin
      drop_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (owner == OWN_I)      state_d = m_gnt_i ? ST_WAIT_I : ST_REQ_I;
        else if (owner == OWN_D) state_d = m_gnt_i ? ST_WAIT_D : ST_REQ_D;
      end
      ST_REQ_I: begin
        if (!i_req_i)     state_d = ST_IDLE;
        else if (m_gnt_i) state_d = ST_WAIT_I;
      end
      ST_REQ_D: begin
        if (m_gnt_i) state_d = ST_WAIT_D;
      end
      ST_WAIT_I, ST_WAIT_D: begin
        if (m_rvalid_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Owner is forced to none while reset is held so every output reads zero.
  always_comb begin
    owner = OWN_NONE;
    if (rstn_i) begin
      case (state_q)
        ST_IDLE:  owner = winner;
        ST_REQ_I: owner = i_req_i ? OWN_I : OWN_NONE;
        ST_REQ_D: owner = OWN_D;
        default:  owner = OWN_NONE;
      endcase
    end

    m_req_o   = (owner != OWN_NONE);
    m_we_o    = 1'b0;
    m_be_o    = '0;
    m_addr_o  = '0;
    m_wdata_o = '0;
    if (owner == OWN_I) begin
      m_be_o   = '1;
      m_addr_o = i_addr_i;
    end else if (owner == OWN_D) begin
      m_we_o    = d_we_i;
      m_be_o    = d_be_i;
      m_addr_o  = d_addr_i;
      m_wdata_o = d_wdata_i;
    end

    i_gnt_o = m_gnt_i && m_req_o && (owner == OWN_I);
    d_gnt_o = m_gnt_i && m_req_o && (owner == OWN_D);

    i_rvalid_o = rstn_i && (state_q == ST_WAIT_I) && m_rvalid_i && !drop_q && softresetn_i;
    d_rvalid_o = rstn_i && (state_q == ST_WAIT_D) && m_rvalid_i;
    i_rdata_o  = i_rvalid_o ? m_rdata_i : '0;
    d_rdata_o  = d_rvalid_o ? m_rdata_i : '0;
  end

endmodule
